// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with a 2-entry skid buffer: registered ready, FIFO order,
// synchronous flush with a saturating drop counter, and zeroed control on bubbles.
module pipe_skid_reg #(
  parameter int CTRL_W     = 16,
  parameter int DATA_W     = 256,
  parameter bit CLEAR_DATA = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  drop_cnt
);

  // Encoding equals the occupancy, so occ is the state register itself.
  typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;

  state_t              r_state, w_state_nxt;
  logic [CTRL_W-1:0]   r_main_ctrl, r_skid_ctrl;
  logic [DATA_W-1:0]   r_main_data, r_skid_data;
  logic [CNT_W-1:0]    r_drop_cnt;

  logic                w_main_vld, w_skid_vld;
  logic                w_in_fire, w_out_fire;
  logic                w_ld_main_in, w_ld_main_skid, w_ld_skid;
  logic [1:0]          w_drop_inc;
  logic [CNT_W+1:0]    w_drop_sum;

  assign w_main_vld = (r_state != EMPTY);
  assign w_skid_vld = (r_state == FULL);
  assign in_ready   = (r_state != FULL);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = w_main_vld & out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      EMPTY: if (w_in_fire) begin
        w_state_nxt  = HALF;
        w_ld_main_in = 1'b1;
      end
      HALF: begin
        if (w_in_fire && w_out_fire) begin
          w_ld_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = FULL;
          w_ld_skid   = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: if (w_out_fire) begin
        w_state_nxt    = HALF;
        w_ld_main_skid = 1'b1;
      end
      default: w_state_nxt = EMPTY;
    endcase
    if (flush) begin
      w_state_nxt    = EMPTY;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
    end
  end

  // An entry leaving on the flush cycle was delivered, so it is not a drop.
  assign w_drop_inc = {1'b0, w_main_vld & ~w_out_fire} + {1'b0, w_skid_vld} + {1'b0, w_in_fire};
  assign w_drop_sum = {2'b00, r_drop_cnt} + (CNT_W+2)'(w_drop_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_main_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_ld_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_ld_skid) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
      if (flush) begin
        if (w_drop_sum[CNT_W+1:CNT_W] != 2'b00) r_drop_cnt <= '1;
        else                                    r_drop_cnt <= w_drop_sum[CNT_W-1:0];
      end
    end
  end

  assign out_valid = w_main_vld;
  assign out_ctrl  = w_main_vld ? r_main_ctrl : '0;
  assign out_data  = (CLEAR_DATA && !w_main_vld) ? '0 : r_main_data;
  assign occ       = r_state;
  assign drop_cnt  = r_drop_cnt;

endmodule
